// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: SPI mode-0 slave that stands in for the two-axis
// joystick module. Takes the 5-byte LED command frame and returns the
// 5-byte position/button report. All SPI pins are oversampled on clk50M.
module jstk_spi_responder (
  input  logic       clk50M,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [1:0] btn,
  output logic [1:0] ld,
  output logic       frame_done,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_t;

  localparam logic [5:0] FRAME_BITS = 6'd40;

  // 2-flop synchronisers plus one history flop per pin
  logic cs_s1, cs_s2, cs_h;
  logic sck_s1, sck_s2, sck_h;
  logic mosi_s1, mosi_s2, mosi_h;

  // armed blocks a frame from starting until cs has been seen high after
  // reset; warm covers the synchroniser still holding reset values
  logic [1:0] warm;
  logic       armed;

  state_t      state;
  logic [5:0]  cnt;
  logic        ovr;
  logic [39:0] tx;
  logic [39:0] rx;

  logic cs_fall, cs_rise, sck_rise, sck_fall;
  logic [39:0] tx_word;

  assign tx_word  = {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 6'b0, btn};
  assign cs_fall  = armed & cs_h & ~cs_s2;
  assign cs_rise  = ~cs_h & cs_s2;
  assign sck_rise = ~sck_h & sck_s2;
  assign sck_fall = sck_h & ~sck_s2;

  // Pin synchronisation, edge history and post-reset arming
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1   <= 1'b1; cs_s2   <= 1'b1; cs_h   <= 1'b1;
      sck_s1  <= 1'b0; sck_s2  <= 1'b0; sck_h  <= 1'b0;
      mosi_s1 <= 1'b0; mosi_s2 <= 1'b0; mosi_h <= 1'b0;
      warm    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      cs_s1   <= cs;   cs_s2   <= cs_s1;   cs_h   <= cs_s2;
      sck_s1  <= sck;  sck_s2  <= sck_s1;  sck_h  <= sck_s2;
      mosi_s1 <= mosi; mosi_s2 <= mosi_s1; mosi_h <= mosi_s2;
      warm    <= {warm[0], 1'b1};
      armed   <= armed | (warm[1] & cs_s2);
    end
  end

  // Frame FSM: shift data on SCK edges, resolve the frame on CS rise
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      ovr        <= 1'b0;
      tx         <= 40'd0;
      rx         <= 40'd0;
      miso       <= 1'b0;
      ld         <= 2'b00;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          cnt  <= 6'd0;
          if (cs_fall) begin
            tx    <= tx_word;
            miso  <= tx_word[39];
            ovr   <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT, WAIT: begin
          if (cs_rise) begin
            // CS rise wins over any SCK edge in the same cycle
            state <= IDLE;
            miso  <= 1'b0;
            cnt   <= 6'd0;
            if (cnt == FRAME_BITS && !ovr && rx[39:34] == 6'b100000) begin
              ld         <= rx[33:32];
              frame_done <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end else if (state == SHIFT) begin
            if (sck_rise) begin
              rx  <= {rx[38:0], mosi_h};
              cnt <= cnt + 6'd1;
              if (cnt == FRAME_BITS - 6'd1) begin
                state <= WAIT;
                miso  <= 1'b0;
              end
            end else if (sck_fall) begin
              miso <= tx[38];
              tx   <= {tx[38:0], 1'b0};
            end
          end else begin
            miso <= 1'b0;
            if (sck_rise) ovr <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
